pixel_packer: RTL
=================

Name: pixel_packer

Overview:
- Downstream stage of the SRAM rotate/transpose adapter.
- Consumes the 8-bit grayscale pixel stream (one pixel per accepted cycle) with start-of-line and end-of-frame markers.
- Packs PACK pixels into one output word and buffers words in a small FIFO.
- Presents the words on a valid/ready interface toward the bus/DMA writer, and flags stream-integrity errors.

Parameters:
- PIX_W, 8: pixel width in bits.
- PACK, 4: pixels per output word (power of two, at least 2).
- LINE_PIX, 256: expected pixels per line, used by the line-length check.
- FIFO_DEPTH, 8: output word FIFO entries (power of two).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel present this cycle. There is no backpressure; the upstream stage is free-running.
- in_data  in  PIX_W  grayscale pixel.
- in_sol  in  1  start of line; qualified by in_valid, marks the first pixel of a line.
- in_eof  in  1  last pixel of frame; qualified by in_valid.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  PIX_W*PACK  packed word.
- out_last  out  1  word contains the frame's last pixel.
- frame_done  out  1  one-cycle pulse when the last word is accepted.
- overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
- line_err  out  1  sticky: a line length differed from LINE_PIX.

Behaviour:
- Reset values: all outputs 0, lane counter 0, pixel counter 0, FIFO empty. Reset mid-frame discards all partial and buffered data immediately.
- Lane accumulator:
  - Each in_valid writes in_data into lane[lane_cnt].
  - Lane 0 occupies bits PIX_W-1:0, i.e. the first pixel is in the LSBs.
  - lane_cnt increments and wraps modulo PACK.
- Word completion happens on the pixel with lane_cnt == PACK-1, or on in_eof with any lane_cnt.
  - On eof, unfilled lanes are zero-padded and the FIFO entry's last bit is set.
  - lane_cnt returns to 0.
- in_sol with lane_cnt != 0:
  - The partial word is discarded, line_err is set, and the current pixel starts lane 0.
  - in_sol with lane_cnt == 0 is normal.
- Line check:
  - pix_cnt counts pixels since the last sol.
  - On in_sol (not the first of the frame), set line_err if pix_cnt != LINE_PIX.
  - On in_eof, check pix_cnt+1 == LINE_PIX.
  - pix_cnt resets to 1 on sol, and to 0 after eof.
- FIFO:
  - Write on word completion if not full. If full, the word is dropped and overflow is set.
  - A pop and a push in the same cycle when full is legal; the push succeeds (read-before-write).
- Output:
  - out_valid = !empty; out_data and out_last come from the FIFO head.
  - The handshake occurs when out_valid && out_ready. out_data is stable while out_valid && !out_ready.
- Latency: a completed word appears on out_valid the cycle after its final pixel is sampled (FIFO was empty).
- frame_done is registered: it pulses the cycle after the handshake of a word with out_last=1.
- overflow and line_err clear only on rst.
- Simultaneous in_sol and in_eof on the same pixel is a 1-pixel line: the line check applies, and the word is flushed with last=1.

Optional Feature:
- Macro: PIXEL_PACKER_MSB_FIRST_EN.
- Defined: lane 0 occupies the top PIX_W bits, later pixels go toward the LSBs, and zero padding is in the low bits.
- Undefined: LSB-first packing as specified above.
- Handshake, counters and flags are identical in both builds.

Decomposition:
- Shared package: PIX_W, PACK, WORD_W = PIX_W*PACK, LANE_CNT_W = clog2(PACK), the FIFO entry struct {last, data}, IMG_W/IMG_H = 256.
- One natural sub-module: sync_fifo (parameterised width/depth, full/empty, simultaneous push/pop).
- Lane accumulator and line checker stay in the top level.

Test Plan:
- Pixels 0x01,0x02,0x03,0x04 with sol on the first, out_ready=1 -> one word 0x04030201, out_valid one cycle after the 4th pixel, out_last=0.
- 256-pixel lines ×2, last pixel with eof, values = index&0xFF -> 128 words, final word 0xFFFEFDFC with out_last=1, frame_done pulses once, line_err=0.
- 6 pixels 0xA0..0xA5 then eof on 0xA6 -> words 0xA3A2A1A0 and 0x00A6A5A4 with last=1.
- out_ready=0 for 40 pixels (10 words, DEPTH 8) -> overflow=1 after the 9th word, only the first 8 words are delivered once ready rises, and overflow stays 1.
- sol after 255 pixels at lane_cnt 3 -> line_err=1, partial word dropped, next word starts at the sol pixel.
- rst asserted mid-frame with 5 words buffered -> out_valid=0 immediately and flags cleared; a following clean frame packs correctly.

Source files
------------

// File: rtl/pixel_packer_pkg.sv
// Shared types and constants for the pixel packer: word geometry, FIFO entry
// layout and the lane placement helper (honours PIXEL_PACKER_MSB_FIRST_EN).
package pixel_packer_pkg;

    localparam int PIX_W      = 8;
    localparam int PACK       = 4;
    localparam int WORD_W     = PIX_W * PACK;
    localparam int LANE_CNT_W = $clog2(PACK);
    localparam int IMG_W      = 256;
    localparam int IMG_H      = 256;
    localparam int LINE_PIX   = IMG_W;
    localparam int FIFO_DEPTH = 8;
    // two spare bits so an over-long line saturates well above LINE_PIX
    localparam int PIX_CNT_W  = $clog2(LINE_PIX) + 2;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

    function automatic logic [WORD_W-1:0] lane_insert(
        input logic [WORD_W-1:0]     word,
        input logic [LANE_CNT_W-1:0] lane,
        input logic [PIX_W-1:0]      pix
    );
        logic [WORD_W-1:0]     res;
        logic [LANE_CNT_W-1:0] pos;
        res = word;
`ifdef PIXEL_PACKER_MSB_FIRST_EN
        pos = LANE_CNT_W'(PACK - 1) - lane;
`else
        pos = lane;
`endif
        res[pos*PIX_W +: PIX_W] = pix;
        return res;
    endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel-in / word-out bundle of the packer. The master side is the packer
// itself; the slave side is the surrounding pipeline (source and consumer).
interface pixel_packer_if;
    import pixel_packer_pkg::*;

    logic              in_valid;
    logic [PIX_W-1:0]  in_data;
    logic              in_sol;
    logic              in_eof;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              frame_done;
    logic              overflow;
    logic              line_err;

    modport master (
        input  in_valid, in_data, in_sol, in_eof, out_ready,
        output out_valid, out_data, out_last, frame_done, overflow, line_err
    );

    modport slave (
        output in_valid, in_data, in_sol, in_eof, out_ready,
        input  out_valid, out_data, out_last, frame_done, overflow, line_err
    );

endinterface

// File: rtl/pixel_packer_sync_fifo.sv
// Synchronous FIFO with registered storage. A push while full is accepted only
// when a pop happens in the same cycle (the head leaves before the tail lands).
module pixel_packer_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == (AW+1)'(0));
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign data_o    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Packs PACK grayscale pixels per word, buffers words, checks line lengths.
// Define PIXEL_PACKER_MSB_FIRST_EN to place the first pixel in the top lane.
module pixel_packer
    import pixel_packer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    pixel_packer_if.master pp
);

    logic [LANE_CNT_W-1:0] lane_cnt_q, lane_cnt_d;
    logic [WORD_W-1:0]     acc_q, acc_d;
    logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic                  first_q, first_d;
    logic                  line_err_q, line_err_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_done_q, frame_done_d;

    logic [LANE_CNT_W-1:0] lane_idx_s;
    logic [WORD_W-1:0]     word_s;
    logic [PIX_CNT_W-1:0]  cnt_base_s;
    logic                  complete_s;
    logic                  sol_err_s;
    logic                  eof_err_s;

    fifo_entry_t           fifo_din_s;
    fifo_entry_t           fifo_dout_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  fifo_pop_s;

    // Lane accumulation, word completion and line-length bookkeeping
    always_comb begin
        lane_idx_s   = lane_cnt_q;
        cnt_base_s   = pix_cnt_q;
        word_s       = acc_q;
        acc_d        = acc_q;
        lane_cnt_d   = lane_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        first_d      = first_q;
        complete_s   = 1'b0;
        sol_err_s    = 1'b0;
        eof_err_s    = 1'b0;

        // a sol restarts the word, so stale lanes are simply overwritten/zeroed
        if (pp.in_sol) begin
            lane_idx_s = '0;
            cnt_base_s = '0;
        end else begin
            lane_idx_s = lane_cnt_q;
            cnt_base_s = pix_cnt_q;
        end

        if (lane_idx_s == '0) begin
            word_s = lane_insert('0, lane_idx_s, pp.in_data);
        end else begin
            word_s = lane_insert(acc_q, lane_idx_s, pp.in_data);
        end

        if (pp.in_valid) begin
            complete_s = pp.in_eof || (lane_idx_s == LANE_CNT_W'(PACK - 1));
            sol_err_s  = pp.in_sol && ((lane_cnt_q != '0) ||
                         (!first_q && (pix_cnt_q != PIX_CNT_W'(LINE_PIX))));
            eof_err_s  = pp.in_eof &&
                         ((cnt_base_s + PIX_CNT_W'(1)) != PIX_CNT_W'(LINE_PIX));
            acc_d      = word_s;
            if (complete_s) begin
                lane_cnt_d = '0;
            end else begin
                lane_cnt_d = lane_idx_s + LANE_CNT_W'(1);
            end
            if (pp.in_eof) begin
                pix_cnt_d = '0;
                first_d   = 1'b1;
            end else if (pp.in_sol) begin
                pix_cnt_d = PIX_CNT_W'(1);
                first_d   = 1'b0;
            end else if (pix_cnt_q != {PIX_CNT_W{1'b1}}) begin
                pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
            end else begin
                pix_cnt_d = pix_cnt_q;
            end
        end else begin
            complete_s = 1'b0;
        end

        line_err_d   = line_err_q | sol_err_s | eof_err_s;
        overflow_d   = overflow_q | (complete_s && fifo_full_s && !fifo_pop_s);
        frame_done_d = fifo_pop_s && fifo_dout_s.last;
    end

    // State and sticky flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt_q   <= '0;
            acc_q        <= '0;
            pix_cnt_q    <= '0;
            first_q      <= 1'b1;
            line_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            acc_q        <= acc_d;
            pix_cnt_q    <= pix_cnt_d;
            first_q      <= first_d;
            line_err_q   <= line_err_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fifo_din_s.last = pp.in_eof;
    assign fifo_din_s.data = word_s;
    assign fifo_pop_s      = !fifo_empty_s && pp.out_ready;

    pixel_packer_sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (complete_s),
        .data_i  (fifo_din_s),
        .pop_i   (fifo_pop_s),
        .data_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign pp.out_valid  = !fifo_empty_s;
    assign pp.out_data   = fifo_dout_s.data;
    assign pp.out_last   = fifo_dout_s.last;
    assign pp.frame_done = frame_done_q;
    assign pp.overflow   = overflow_q;
    assign pp.line_err   = line_err_q;

endmodule
